// File: rtl/bcd_7seg_scan.sv
// Two-digit multiplexed 7-segment driver for a latched BCD byte.
// Alternates units/tens every SCAN_DIV cycles, blanks a leading zero and shows a dash for non-BCD nibbles.
module bcd_7seg_scan #(
  parameter int SCAN_DIV = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bcd_in,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       bcd_err
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  typedef enum logic {DIG0, DIG1} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] scan_cnt;
  logic [CW-1:0] cnt_next;
  logic [7:0]    disp_q;
  logic [3:0]    nibble;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DIG0;
      scan_cnt <= '0;
      disp_q   <= 8'h00;
    end else begin
      state    <= state_next;
      scan_cnt <= cnt_next;
      if (load)
        disp_q <= bcd_in;
    end
  end

  // Loading never disturbs the scan timing; only the counter wrap flips the digit.
  always_comb begin
    state_next = state;
    cnt_next   = scan_cnt + 1'b1;
    if (scan_cnt == CNT_MAX) begin
      cnt_next   = '0;
      state_next = (state == DIG0) ? DIG1 : DIG0;
    end
  end

  always_comb begin
    an      = 2'b01;
    nibble  = disp_q[3:0];
    bcd_err = (disp_q[7:4] > 4'd9) || (disp_q[3:0] > 4'd9);
    if (state == DIG1) begin
      an     = 2'b10;
      nibble = disp_q[7:4];
    end
    seg = seg_decode(nibble);
    // The tens enable stays on while blanked so both digits keep equal duty cycle.
    if (BLANK_LZ && state == DIG1 && disp_q[7:4] == 4'd0)
      seg = 7'h00;
  end

endmodule
